// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding, defaults and
// a one-hot decoding helper used for the round-robin pointer update.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  localparam int unsigned DEFAULT_TIMEOUT = 8;
  localparam int unsigned MAX_REQ         = 8;

  function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/memory_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after the
// pointer, wrapping around, returned as a one-hot winner.
module rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               any_valid
);

  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((32'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
    any_valid = |req;
  end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NUM_REQ requesters.
// The winner's command is latched, so memory-side outputs never follow req_* inputs.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned MEMORY_WIDTH  = 8,
  parameter int unsigned MEMORY_DEPTH  = 16,
  parameter int unsigned ADDRESS_WIDTH = $clog2(MEMORY_DEPTH),
  parameter int unsigned TIMEOUT       = DEFAULT_TIMEOUT
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  input  logic [NUM_REQ-1:0]                 req_wr_rd_i,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ*MEMORY_WIDTH-1:0]    req_wdata_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  output logic                               req_err_o,
  output logic [MEMORY_WIDTH-1:0]            req_rdata_o,
  output logic [NUM_REQ-1:0]                 grant_o,
  output logic                               mem_valid_o,
  output logic                               mem_wr_rd_o,
  output logic [ADDRESS_WIDTH-1:0]           mem_addr_o,
  output logic [MEMORY_WIDTH-1:0]            mem_wdata_o,
  input  logic                               mem_ready_i,
  input  logic [MEMORY_WIDTH-1:0]            mem_rdata_i
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  arb_state_e                state_q, state_d;
  logic [PTR_W-1:0]          ptr_q;
  logic [PTR_W-1:0]          next_ptr;
  logic [CNT_W-1:0]          cnt_q;
  logic [NUM_REQ-1:0]        grant_q;
  logic                      wr_q;
  logic [ADDRESS_WIDTH-1:0]  addr_q;
  logic [MEMORY_WIDTH-1:0]   wdata_q;
  logic [MEMORY_WIDTH-1:0]   rdata_q;
  logic                      err_q;

  logic [NUM_REQ-1:0]        pick;
  logic                      any_valid;
  logic                      sel_wr;
  logic [ADDRESS_WIDTH-1:0]  sel_addr;
  logic [MEMORY_WIDTH-1:0]   sel_wdata;
  logic                      timeout_hit;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req       (req_valid_i),
    .ptr       (ptr_q),
    .winner    (pick),
    .any_valid (any_valid)
  );

  // AND-OR mux of the winner's command fields; pick is one-hot or zero.
  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (pick[k]) begin
        sel_wr    = req_wr_rd_i[k];
        sel_addr  = req_addr_i[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        sel_wdata = req_wdata_i[k*MEMORY_WIDTH +: MEMORY_WIDTH];
      end
    end
  end

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign next_ptr    = PTR_W'((onehot_to_idx(MAX_REQ'(grant_q)) + 1) % NUM_REQ);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (any_valid) state_d = ST_ACCESS;
      ST_ACCESS: if (mem_ready_i || timeout_hit) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Ready is tested before the timeout so a response on the last cycle still succeeds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_valid) begin
            grant_q <= pick;
            wr_q    <= sel_wr;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
          end
        end
        ST_ACCESS: begin
          if (mem_ready_i) begin
            rdata_q <= wr_q ? '0 : mem_rdata_i;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
          cnt_q <= cnt_q + CNT_W'(1);
        end
        ST_RESP: begin
          grant_q <= '0;
          cnt_q   <= '0;
          ptr_q   <= next_ptr;
        end
        default: ;
      endcase
    end
  end

  assign grant_o     = grant_q;
  assign req_ready_o = (state_q == ST_RESP) ? grant_q : '0;
  assign req_err_o   = (state_q == ST_RESP) & err_q;
  assign req_rdata_o = (state_q == ST_RESP) ? rdata_q : '0;
  assign mem_valid_o = (state_q == ST_ACCESS);
  assign mem_wr_rd_o = wr_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

endmodule
